wb_burst_master: RTL and testbench
==================================

Name: wb_burst_master

Overview:
Parametrised Wishbone B3 master engine for the Ethernet MAC environment. Executes one command per transaction: single (classic) or incrementing/wrapping bursts, either direction, with CTI/BTE generation, write-data streaming, read-data return, error and timeout abort. Sits between the DMA/sequencer side and the shared Wishbone bus. It supersedes the fixed-width master struct.

Parameters:
ADDR_WIDTH, 32, bus byte-address width
DATA_WIDTH, 32, bus data width (multiple of 8)
SEL_WIDTH, DATA_WIDTH/8, byte-select width
MAX_BURST, 16, max beats per command (>=16)
LEN_WIDTH, 5, cmd_len_i width (must hold MAX_BURST)
TIMEOUT, 256, cycles without ack/err before abort (0 = disabled)

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
cmd_valid_i/cmd_ready_o  in/out  1  command handshake
cmd_addr_i  in  ADDR_WIDTH  start byte address
cmd_len_i  in  LEN_WIDTH  beat count
cmd_we_i  in  1  1=write, 0=read
cmd_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16
cmd_sel_i  in  SEL_WIDTH  byte selects, applied to every beat
wdat_valid_i/wdat_ready_o  in/out  1  write-data handshake
wdat_i  in  DATA_WIDTH  write beat
rdat_valid_o  out  1  read beat valid (no backpressure)
rdat_o  out  DATA_WIDTH  read beat
rdat_last_o  out  1  last read beat
done_o  out  1  one-cycle completion pulse
err_o  out  1  qualifies done_o: bus error, timeout or illegal command
m_wb_adr_o  out  ADDR_WIDTH ; m_wb_sel_o  out  SEL_WIDTH ; m_wb_we_o  out  1 ; m_wb_dat_o  out  DATA_WIDTH ; m_wb_dat_i  in  DATA_WIDTH ; m_wb_cyc_o, m_wb_stb_o  out  1 ; m_wb_ack_i, m_wb_err_i  in  1 ; m_wb_cti_o  out  3 ; m_wb_bte_o  out  2

Behaviour:
- Reset: state IDLE. All outputs are 0, including cmd_ready_o. cmd_ready_o rises on the first clock after deassertion. Reset mid-burst drops cyc/stb immediately. No done_o is emitted.
- All outputs are registered except wdat_ready_o.
- States: IDLE, WDATA (write, waiting for a beat), BUS (stb high), FIN.
- IDLE: cmd_ready_o=1. On accept, latch the command and clear beat counter and timer.
  - cmd_len_i==0 or >MAX_BURST is illegal: go to FIN with err, no bus activity.
  - Otherwise go to BUS (read) or WDATA (write). cyc/stb rise the cycle after accept.
- Address: low log2(SEL_WIDTH) bits forced to 0.
  - Linear: +SEL_WIDTH per ack.
  - Wrap-N: the word index modulo N increments, and the upper bits are held.
- m_wb_bte_o = latched bte.
- m_wb_cti_o:
  - 000 when len==1.
  - Otherwise 010 for beats 0..len-2, and 111 on the final beat.
  - 111 is also driven on an abort.
- WDATA: cyc=1, stb=0, wdat_ready_o=1. On wdat_valid_i, load m_wb_dat_o and go to BUS.
- BUS, write:
  - wdat_ready_o = m_wb_ack_i && !last.
  - On ack with wdat_valid_i, load the next beat and keep stb=1 (zero-bubble).
  - On ack without data, go to WDATA with stb=0 and cyc held.
- BUS, read: each ack registers m_wb_dat_i to rdat_o with rdat_valid_o=1 the next cycle. rdat_last_o is set on the final beat.
- Ack on the final beat: cyc/stb/we/cti go to 0 next cycle, state FIN.
- m_wb_err_i (ack ignored if both): abort.
  - cyc/stb drop next cycle and state goes to FIN with err.
  - Unconsumed write beats are not fetched.
  - A read beat on an err cycle is not forwarded.
- Timeout: the timer counts cycles in BUS without ack/err and resets on each ack. Reaching TIMEOUT aborts like err. The timer is frozen in WDATA.
- FIN: done_o=1 (err_o=1 if aborted/illegal) for one cycle, then IDLE. cmd_ready_o=1 again the cycle after FIN.
- A new command is never accepted while cyc is high. Back-to-back commands have cyc low for ≥2 cycles.

Decomposition:
- wb_burst_pkg: cti_t (CLASSIC=000, INCR=010, EOB=111), bte_t, state_t, and a wrap-length function.
- Sub-module wb_addr_gen: combinational next-address from current address, bte and SEL_WIDTH.

Test Plan:
- Single read at 0x104, len=1, ack after 2 wait cycles.
  -> adr=0x104, cti=000, one rdat_valid_o with rdat_last_o, done_o err_o=0.
- Write len=4 linear at 0x200, wdat always valid.
  -> adr 0x200/204/208/20C on consecutive acks, cti 010,010,010,111, stb never drops.
- Wrap4 read at 0x0C, len=4.
  -> adr 0x0C,0x00,0x04,0x08, bte=01, last cti=111.
- Write len=3 with wdat_valid_i low for 3 cycles after beat 1.
  -> stb=0, cyc=1 during the gap, all 3 beats delivered in order.
- Read len=8 with m_wb_err_i on beat 3.
  -> 2 rdat beats forwarded, cyc low next cycle, done_o+err_o. A cmd with len=0 gives done_o+err_o, cyc never rises.
- Slave never acks (TIMEOUT=16).
  -> abort after 16 BUS cycles with err_o. Async reset asserted mid-burst clears cyc/stb immediately with no done_o.

Source files
------------

// File: rtl/wb_burst_pkg.sv
// Shared types for the Wishbone B3 burst master.
// Cycle-type tags, burst-type encodings, FSM states.
package wb_burst_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_BUS,
    S_FIN
  } state_t;

  // Beats per wrap window; linear reports 1 (no window).
  function automatic logic [4:0] wrap_len(bte_t b);
    logic [4:0] n;
    case (b)
      BTE_WRAP4:  n = 5'd4;
      BTE_WRAP8:  n = 5'd8;
      BTE_WRAP16: n = 5'd16;
      default:    n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_burst_master_addr_gen.sv
// Next beat address for linear and wrapping bursts.
// Word-aligned; wrap keeps the bits above the window.
module wb_addr_gen
  import wb_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [1:0]            bte_i,
  output logic [ADDR_WIDTH-1:0] nxt_o
);

  localparam int OFF = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 0;
  localparam logic [ADDR_WIDTH-1:0] LMASK =
    ~ADDR_WIDTH'(SEL_WIDTH - 1);

  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] wmask;

  always_comb begin
    inc = adr_i + ADDR_WIDTH'(SEL_WIDTH);
    if (bte_i == BTE_LINEAR) begin
      wmask = '1;
    end else begin
      wmask = ADDR_WIDTH'(wrap_len(bte_t'(bte_i)) - 5'd1) << OFF;
    end
    nxt_o = ((adr_i & ~wmask) | (inc & wmask)) & LMASK;
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one command per transaction,
// classic or incr/wrap bursts, error and timeout abort.
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 5,
  parameter int TIMEOUT    = 256
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  cmd_we_i,
  input  logic [1:0]            cmd_bte_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  input  logic                  wdat_valid_i,
  output logic                  wdat_ready_o,
  input  logic [DATA_WIDTH-1:0] wdat_i,
  output logic                  rdat_valid_o,
  output logic [DATA_WIDTH-1:0] rdat_o,
  output logic                  rdat_last_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] m_wb_adr_o,
  output logic [SEL_WIDTH-1:0]  m_wb_sel_o,
  output logic                  m_wb_we_o,
  output logic [DATA_WIDTH-1:0] m_wb_dat_o,
  input  logic [DATA_WIDTH-1:0] m_wb_dat_i,
  output logic                  m_wb_cyc_o,
  output logic                  m_wb_stb_o,
  input  logic                  m_wb_ack_i,
  input  logic                  m_wb_err_i,
  output logic [2:0]            m_wb_cti_o,
  output logic [1:0]            m_wb_bte_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LMASK =
    ~ADDR_WIDTH'(SEL_WIDTH - 1);

  state_t                state_q;
  logic                  cmd_ready_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  cyc_q;
  logic                  stb_q;
  cti_t                  cti_q;
  logic [1:0]            bte_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [LEN_WIDTH-1:0]  beat_inc;
  logic [TW-1:0]         timer_q;
  logic [DATA_WIDTH-1:0] rdat_q;
  logic                  rdat_valid_q;
  logic                  rdat_last_q;
  logic                  done_q;
  logic                  err_q;

  logic last;
  logic ack_ok;
  logic tmo;
  logic illegal;

  function automatic cti_t cti_for(
    logic [LEN_WIDTH-1:0] b,
    logic [LEN_WIDTH-1:0] l
  );
    cti_t c;
    if (l == LEN_WIDTH'(1)) c = CTI_CLASSIC;
    else if (b == l - LEN_WIDTH'(1)) c = CTI_EOB;
    else c = CTI_INCR;
    return c;
  endfunction

  wb_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_addr_gen (
    .adr_i(adr_q),
    .bte_i(bte_q),
    .nxt_o(adr_d)
  );

  assign beat_inc = beat_q + LEN_WIDTH'(1);
  assign last     = (beat_q == len_q - LEN_WIDTH'(1));
  assign ack_ok   = m_wb_ack_i && !m_wb_err_i;
  assign tmo      = (TIMEOUT != 0) &&
                    (timer_q == TW'(TIMEOUT - 1));
  assign illegal  = (cmd_len_i == '0) ||
                    (cmd_len_i > LEN_WIDTH'(MAX_BURST));

  // Only combinational output: lets the next beat ride the ack.
  assign wdat_ready_o = (state_q == S_WDATA) ||
                        ((state_q == S_BUS) && we_q &&
                         ack_ok && !last);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      dat_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      cti_q        <= CTI_CLASSIC;
      bte_q        <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      timer_q      <= '0;
      rdat_q       <= '0;
      rdat_valid_q <= 1'b0;
      rdat_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdat_valid_q <= 1'b0;
      rdat_last_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            adr_q       <= cmd_addr_i & LMASK;
            sel_q       <= cmd_sel_i;
            bte_q       <= cmd_bte_i;
            len_q       <= cmd_len_i;
            beat_q      <= '0;
            timer_q     <= '0;
            cti_q       <= cti_for('0, cmd_len_i);
            if (illegal) begin
              cti_q   <= CTI_CLASSIC;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_FIN;
            end else if (cmd_we_i) begin
              we_q    <= 1'b1;
              cyc_q   <= 1'b1;
              state_q <= S_WDATA;
            end else begin
              we_q    <= 1'b0;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              state_q <= S_BUS;
            end
          end
        end
        S_WDATA: begin
          if (wdat_valid_i) begin
            dat_q   <= wdat_i;
            stb_q   <= 1'b1;
            state_q <= S_BUS;
          end
        end
        S_BUS: begin
          if (m_wb_err_i || (!m_wb_ack_i && tmo)) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            cti_q   <= CTI_EOB;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_FIN;
          end else if (m_wb_ack_i) begin
            timer_q <= '0;
            if (!we_q) begin
              rdat_q       <= m_wb_dat_i;
              rdat_valid_q <= 1'b1;
              rdat_last_q  <= last;
            end
            if (last) begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              we_q    <= 1'b0;
              cti_q   <= CTI_CLASSIC;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              beat_q <= beat_inc;
              adr_q  <= adr_d;
              cti_q  <= cti_for(beat_inc, len_q);
              if (we_q) begin
                if (wdat_valid_i) begin
                  dat_q <= wdat_i;
                end else begin
                  stb_q   <= 1'b0;
                  state_q <= S_WDATA;
                end
              end
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_FIN: begin
          cmd_ready_q <= 1'b1;
          cti_q       <= CTI_CLASSIC;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rdat_valid_o = rdat_valid_q;
  assign rdat_o       = rdat_q;
  assign rdat_last_o  = rdat_last_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign m_wb_adr_o   = adr_q;
  assign m_wb_sel_o   = sel_q;
  assign m_wb_we_o    = we_q;
  assign m_wb_dat_o   = dat_q;
  assign m_wb_cyc_o   = cyc_q;
  assign m_wb_stb_o   = stb_q;
  assign m_wb_cti_o   = cti_q;
  assign m_wb_bte_o   = bte_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: directed commands,
// modelled slave and write feeder, queue-based monitor.
module tb_wb_burst_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        cmd_we;
  logic [1:0]  cmd_bte;
  logic [3:0]  cmd_sel;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdat;
  logic        rvalid;
  logic [31:0] rdat;
  logic        rlast;
  logic        done;
  logic        err;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        berr;
  logic [2:0]  cti;
  logic [1:0]  bte;

  wb_burst_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SEL_WIDTH (4),
    .MAX_BURST (16),
    .LEN_WIDTH (5),
    .TIMEOUT   (16)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .cmd_we_i    (cmd_we),
    .cmd_bte_i   (cmd_bte),
    .cmd_sel_i   (cmd_sel),
    .wdat_valid_i(wvalid),
    .wdat_ready_o(wready),
    .wdat_i      (wdat),
    .rdat_valid_o(rvalid),
    .rdat_o      (rdat),
    .rdat_last_o (rlast),
    .done_o      (done),
    .err_o       (err),
    .m_wb_adr_o  (adr),
    .m_wb_sel_o  (sel),
    .m_wb_we_o   (we),
    .m_wb_dat_o  (dat_o),
    .m_wb_dat_i  (dat_i),
    .m_wb_cyc_o  (cyc),
    .m_wb_stb_o  (stb),
    .m_wb_ack_i  (ack),
    .m_wb_err_i  (berr),
    .m_wb_cti_o  (cti),
    .m_wb_bte_o  (bte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
    logic [1:0]  bte;
    logic [3:0]  sel;
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
  } rd_t;

  beat_t       exp_bus[$];
  rd_t         exp_rd[$];
  logic        exp_done[$];
  logic [31:0] wq[$];

  int n_tests = 0;
  int n_fail  = 0;

  int s_wait    = 0;
  int s_errbeat = -1;
  int s_noack   = 0;
  int s_cnt     = 0;
  int s_beat    = 0;

  int hold_after  = 0;
  int hold_cycles = 0;
  int f_sent      = 0;
  int f_gap       = 0;

  int   stb_gap    = 0;
  int   stb_cycles = 0;
  int   cyc_cycles = 0;
  logic seen_stb   = 1'b0;
  logic prev_abort = 1'b0;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  task automatic push_bus(input logic [31:0] a,
                          input logic [2:0] c,
                          input logic w,
                          input logic [31:0] d,
                          input logic [1:0] b,
                          input logic [3:0] s);
    beat_t e;
    e.adr = a; e.cti = c; e.we = w;
    e.dat = d; e.bte = b; e.sel = s;
    exp_bus.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] d, input logic l);
    rd_t e;
    e.dat = d; e.last = l;
    exp_rd.push_back(e);
  endtask

  // Slave: ack/err decided just after each edge from stb.
  initial begin
    ack = 1'b0; berr = 1'b0; dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      ack = 1'b0;
      berr = 1'b0;
      if (rst_n && cyc && stb && s_noack == 0) begin
        if (s_cnt >= s_wait) begin
          if (s_beat == s_errbeat) berr = 1'b1;
          else begin
            ack = 1'b1;
            dat_i = rd_of(adr);
          end
          s_beat++;
          s_cnt = 0;
        end else s_cnt++;
      end else s_cnt = 0;
    end
  end

  // Write feeder with an optional stall after a given beat.
  initial begin
    logic hs;
    wvalid = 1'b0; wdat = '0;
    forever begin
      @(negedge clk);
      hs = wvalid && wready;
      @(posedge clk);
      #1;
      if (hs) begin
        void'(wq.pop_front());
        f_sent++;
        if (f_sent == hold_after) f_gap = hold_cycles;
      end
      if (f_gap > 0) begin
        wvalid = 1'b0;
        f_gap--;
      end else if (wq.size() > 0) begin
        wvalid = 1'b1;
        wdat = wq[0];
      end else wvalid = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents output.
  initial begin
    beat_t b;
    rd_t   r;
    logic  e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cyc) cyc_cycles++;
        if (cyc && stb) stb_cycles++;
        if (!cyc) seen_stb = 1'b0;
        else begin
          if (!stb && seen_stb) stb_gap++;
          if (stb) seen_stb = 1'b1;
        end
        if (prev_abort) chk("cyc_after_err", {31'd0, cyc}, 32'd0);
        prev_abort = cyc && stb && berr;
        if (cyc && stb && ack && !berr) begin
          if (exp_bus.size() == 0) unexpected("bus_beat");
          else begin
            b = exp_bus.pop_front();
            chk("adr", adr, b.adr);
            chk("cti", {29'd0, cti}, {29'd0, b.cti});
            chk("we", {31'd0, we}, {31'd0, b.we});
            chk("bte", {30'd0, bte}, {30'd0, b.bte});
            chk("sel", {28'd0, sel}, {28'd0, b.sel});
            if (b.we) chk("wdat", dat_o, b.dat);
          end
        end
        if (rvalid) begin
          if (exp_rd.size() == 0) unexpected("rdat");
          else begin
            r = exp_rd.pop_front();
            chk("rdat", rdat, r.dat);
            chk("rlast", {31'd0, rlast}, {31'd0, r.last});
          end
        end
        if (done) begin
          if (exp_done.size() == 0) unexpected("done");
          else begin
            e = exp_done.pop_front();
            chk("err", {31'd0, err}, {31'd0, e});
          end
        end
      end else prev_abort = 1'b0;
    end
  end

  task automatic clr_stats;
    s_cnt = 0; s_beat = 0;
    stb_gap = 0; stb_cycles = 0; cyc_cycles = 0;
    f_sent = 0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [4:0] l,
                       input logic w, input logic [1:0] b,
                       input logic [3:0] s);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_addr = a; cmd_len = l; cmd_we = w;
    cmd_bte = b; cmd_sel = s;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k >= 300) chk({name, "_done_wait"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({name, "_bus_left"}, exp_bus.size(), 32'd0);
    chk({name, "_rd_left"}, exp_rd.size(), 32'd0);
    chk({name, "_done_left"}, exp_done.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_we = 1'b0; cmd_bte = '0; cmd_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_cti", {29'd0, cti}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_first_clk", {31'd0, cmd_ready}, 32'd1);

    // Single classic read, two wait states.
    clr_stats(); s_wait = 2;
    push_bus(32'h104, 3'b000, 1'b0, 32'h0, 2'b00, 4'hF);
    push_rd(rd_of(32'h104), 1'b1);
    exp_done.push_back(1'b0);
    issue(32'h104, 5'd1, 1'b0, 2'b00, 4'hF);
    wait_done("single_rd");
    chk("single_stb_cycles", stb_cycles, 32'd3);

    // Linear write x4, data always available.
    clr_stats(); s_wait = 0;
    wq = '{32'h1111_1111, 32'h2222_2222,
           32'h3333_3333, 32'h4444_4444};
    push_bus(32'h200, 3'b010, 1'b1, 32'h1111_1111, 2'b00, 4'h3);
    push_bus(32'h204, 3'b010, 1'b1, 32'h2222_2222, 2'b00, 4'h3);
    push_bus(32'h208, 3'b010, 1'b1, 32'h3333_3333, 2'b00, 4'h3);
    push_bus(32'h20C, 3'b111, 1'b1, 32'h4444_4444, 2'b00, 4'h3);
    exp_done.push_back(1'b0);
    issue(32'h200, 5'd4, 1'b1, 2'b00, 4'h3);
    wait_done("wr_lin4");
    chk("wr_lin4_stb_gap", stb_gap, 32'd0);
    chk("wr_lin4_stb_cycles", stb_cycles, 32'd4);

    // Wrap4 read starting at the last word of the window.
    clr_stats(); s_wait = 1;
    push_bus(32'h0C, 3'b010, 1'b0, 32'h0, 2'b01, 4'hF);
    push_bus(32'h00, 3'b010, 1'b0, 32'h0, 2'b01, 4'hF);
    push_bus(32'h04, 3'b010, 1'b0, 32'h0, 2'b01, 4'hF);
    push_bus(32'h08, 3'b111, 1'b0, 32'h0, 2'b01, 4'hF);
    push_rd(rd_of(32'h0C), 1'b0);
    push_rd(rd_of(32'h00), 1'b0);
    push_rd(rd_of(32'h04), 1'b0);
    push_rd(rd_of(32'h08), 1'b1);
    exp_done.push_back(1'b0);
    issue(32'h0C, 5'd4, 1'b0, 2'b01, 4'hF);
    wait_done("rd_wrap4");

    // Write x3 with a three-cycle data gap after the first beat.
    clr_stats(); s_wait = 0;
    hold_after = 1; hold_cycles = 3;
    wq = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
    push_bus(32'h500, 3'b010, 1'b1, 32'hAAAA_0001, 2'b00, 4'hF);
    push_bus(32'h504, 3'b010, 1'b1, 32'hAAAA_0002, 2'b00, 4'hF);
    push_bus(32'h508, 3'b111, 1'b1, 32'hAAAA_0003, 2'b00, 4'hF);
    exp_done.push_back(1'b0);
    issue(32'h500, 5'd3, 1'b1, 2'b00, 4'hF);
    wait_done("wr_gap");
    chk("wr_gap_stb_gap", stb_gap, 32'd3);
    hold_after = 0; hold_cycles = 0;

    // Read x8 with a bus error on the third beat.
    clr_stats(); s_wait = 0; s_errbeat = 2;
    push_bus(32'h300, 3'b010, 1'b0, 32'h0, 2'b00, 4'hF);
    push_bus(32'h304, 3'b010, 1'b0, 32'h0, 2'b00, 4'hF);
    push_rd(rd_of(32'h300), 1'b0);
    push_rd(rd_of(32'h304), 1'b0);
    exp_done.push_back(1'b1);
    issue(32'h300, 5'd8, 1'b0, 2'b00, 4'hF);
    wait_done("rd_err");
    s_errbeat = -1;

    // Illegal lengths: zero and above the maximum.
    clr_stats();
    exp_done.push_back(1'b1);
    issue(32'h40, 5'd0, 1'b0, 2'b00, 4'hF);
    wait_done("len0");
    chk("len0_cyc_cycles", cyc_cycles, 32'd0);
    clr_stats();
    exp_done.push_back(1'b1);
    issue(32'h40, 5'd17, 1'b1, 2'b00, 4'hF);
    wait_done("len17");
    chk("len17_cyc_cycles", cyc_cycles, 32'd0);

    // Silent slave: timeout abort.
    clr_stats(); s_noack = 1;
    exp_done.push_back(1'b1);
    issue(32'h600, 5'd4, 1'b0, 2'b00, 4'hF);
    wait_done("timeout");
    chk("timeout_stb_cycles", stb_cycles, 32'd16);
    s_noack = 0;

    // Asynchronous reset in the middle of a burst.
    clr_stats(); s_wait = 20;
    issue(32'h700, 5'd8, 1'b0, 2'b00, 4'hF);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_cyc", {31'd0, cyc}, 32'd0);

    // Recovery after reset: short linear read.
    clr_stats(); s_wait = 0;
    push_bus(32'h800, 3'b010, 1'b0, 32'h0, 2'b00, 4'hF);
    push_bus(32'h804, 3'b111, 1'b0, 32'h0, 2'b00, 4'hF);
    push_rd(rd_of(32'h800), 1'b0);
    push_rd(rd_of(32'h804), 1'b1);
    exp_done.push_back(1'b0);
    issue(32'h802, 5'd2, 1'b0, 2'b00, 4'hF);
    wait_done("recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
